// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B, one bit per clock, LSB first.
// A borrow flop carries between bit positions. Operands are captured on an
// accepted start. A one-cycle done pulse marks a fresh D/BO.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_nxt;
    logic [CNT_W-1:0] cnt;
    logic             bf;
    logic             bit_d;
    logic             bf_nxt;
    logic             accept;
    logic             last_bit;

    // Full-subtractor cell acting on the current LSB pair and the held borrow
    always_comb begin
        bit_d  = a_sr[0] ^ b_sr[0] ^ bf;
        bf_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bf);
    end

    // The new difference bit enters at the MSB so the result is aligned after WIDTH shifts
    generate
        if (WIDTH == 1) begin : g_r_one
            assign r_nxt = bit_d;
        end else begin : g_r_wide
            assign r_nxt = {bit_d, r_sr[WIDTH-1:1]};
        end
    endgenerate

    // Next-state logic: start is honoured in IDLE and DONE, ignored while running
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, bit counter, borrow flop and the registered result/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            bf    <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            BO    <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            if (accept) begin
                bf  <= 1'b0;
                cnt <= '0;
            end else if (state == RUN) begin
                bf  <= bf_nxt;
                cnt <= cnt + 1'b1;
                if (last_bit) begin
                    D  <= r_nxt;
                    BO <= bf_nxt;
                end
            end
        end
    end

    // Operand and partial-result shift registers; contents are don't-care outside RUN
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr <= A;
            b_sr <= B;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= r_nxt;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit and a 1-bit instance share clock and reset.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
    logic       busy;
    logic       done;
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] d1;
    logic       bo1;
    logic       busy1;
    logic       done1;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
        .D(d), .BO(bo), .busy(busy), .done(done)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
        .D(d1), .BO(bo1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       bo;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   done8_cnt = 0;
    int   done1_cnt = 0;
    exp_t q8[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse pops the oldest expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done8_cnt++;
            n_vec++;
            if (q8.size() == 0) begin
                n_err++;
                $display("FAIL w8_done_unexpected: got D=%0h BO=%0b with nothing expected", d, bo);
            end else begin
                e = q8.pop_front();
                if (d !== e.d || bo !== e.bo) begin
                    n_err++;
                    $display("FAIL w8_result: got D=%0h BO=%0b expected D=%0h BO=%0b", d, bo, e.d, e.bo);
                end
            end
        end
        if (done1 === 1'b1) begin
            exp_t e;
            done1_cnt++;
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL w1_done_unexpected: got D=%0b BO=%0b with nothing expected", d1, bo1);
            end else begin
                e = q1.pop_front();
                if ({7'd0, d1} !== e.d || bo1 !== e.bo) begin
                    n_err++;
                    $display("FAIL w1_result: got D=%0b BO=%0b expected D=%0h BO=%0b", d1, bo1, e.d, e.bo);
                end
            end
        end
    end

    // Pulse start for one edge on the 8-bit unit and queue the expected result
    task automatic launch8(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] ed, input logic ebo);
        exp_t e;
        e.d  = ed;
        e.bo = ebo;
        q8.push_back(e);
        a     = va;
        b     = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 8'hxx;
        b     = 8'hxx;
    endtask

    // Run until busy drops; returns busy length and whether D moved meanwhile
    task automatic wait_idle8(input logic [7:0] hold_d, output int busy_len, output int d_moved);
        busy_len = 0;
        d_moved  = 0;
        while (busy === 1'b1 && busy_len < 20) begin
            busy_len++;
            if (d !== hold_d) d_moved = 1;
            tick();
        end
    endtask

    vec_t       vecs[8];
    int         blen;
    int         dmov;
    int         base;
    int         bad;
    int         dt[$];
    logic [7:0] prev_d;
    logic       prev_bo;

    initial begin
        vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
        vecs[3] = '{8'hC8, 8'h64, 8'h64, 1'b0};
        vecs[4] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        a1     = 1'b0;
        b1     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_D", d, 8'h00);
        chk("rst_BO", bo, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_w1_busy", busy1, 1'b0);
        chk("rst_w1_D", d1, 1'b0);

        // Table vectors, back-to-back: each next start lands in the previous DONE cycle
        prev_d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            launch8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo);
            wait_idle8(prev_d, blen, dmov);
            chk($sformatf("v%0d_busy_len", i), blen, 8);
            chk($sformatf("v%0d_d_hold", i), dmov, 0);
            chk($sformatf("v%0d_done", i), done, 1'b1);
            prev_d = vecs[i].d;
        end
        tick();
        chk("idle_after_table", {busy, done}, 2'b00);

        // Start while busy is ignored
        base = done8_cnt;
        launch8(8'h10, 8'h01, 8'h0F, 1'b0);
        tick();
        tick();
        a     = 8'hFF;
        b     = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 20; t++) tick();
        chk("ign_done_count", done8_cnt - base, 1);
        chk("ign_D", d, 8'h0F);
        chk("ign_idle", busy, 1'b0);

        // Reset in the middle of a run aborts it silently
        base    = done8_cnt;
        prev_bo = bo;
        launch8(8'h5A, 8'h23, 8'h37, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(q8.pop_back());
        chk("abort_D", d, 8'h00);
        chk("abort_BO", bo, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        for (int t = 0; t < 12; t++) tick();
        chk("abort_no_done", done8_cnt - base, 0);
        launch8(8'h03, 8'h05, 8'hFE, 1'b1);
        wait_idle8(8'h00, blen, dmov);
        chk("post_abort_len", blen, 8);
        chk("post_abort_D", d, 8'hFE);
        chk("post_abort_BO", bo, 1'b1);
        tick();

        // start held high: re-accepted every DONE cycle, three results then drop
        for (int k = 0; k < 3; k++) q8.push_back('{8'h64, 1'b0});
        a     = 8'hC8;
        b     = 8'h64;
        start = 1'b1;
        tick();
        bad = 0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (t == 18) start = 1'b0;
            if (done === 1'b1) begin
                dt.push_back(t);
                if (busy !== 1'b0) bad++;
            end else if (t < 26 && busy !== 1'b1) begin
                bad++;
            end
        end
        chk("cont_done_n", dt.size(), 3);
        if (dt.size() == 3) begin
            chk("cont_t0", dt[0], 8);
            chk("cont_t1", dt[1], 17);
            chk("cont_t2", dt[2], 26);
        end
        chk("cont_busy_shape", bad, 0);
        chk("cont_D", d, 8'h64);

        // One-bit instance, exhaustive
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            logic va;
            logic vb;
            va   = i[1];
            vb   = i[0];
            e.d  = {7'd0, va ^ vb};
            e.bo = ~va & vb;
            q1.push_back(e);
            a1     = va;
            b1     = vb;
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk($sformatf("w1_%0d_busy", i), {busy1, done1}, 2'b10);
            tick();
            chk($sformatf("w1_%0d_done", i), {busy1, done1}, 2'b01);
            tick();
        end

        tick();
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
